demux_one_hot_buffered: RTL and testbench

- Inverse of the one-hot select path: a single producer stream carries a one-hot destination select.
- Each accepted beat is steered to exactly one of COUNT consumer channels.
- Each consumer channel has its own small synchronous FIFO with valid/ready, so one stalled consumer does not block beats headed to the others.
- Sits between a shared producer (e.g. a writeback or response bus) and per-requestor consumers.

---
 rtl/demux_one_hot_buffered_pkg.sv | 11 +
 rtl/demux_lane_fifo.sv | 49 ++++
 rtl/demux_one_hot_buffered.sv | 53 +++++
 tb/tb_demux_one_hot_buffered.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/demux_one_hot_buffered_pkg.sv
// Shared helpers for the one-hot buffered demux: select legality check.
package demux_one_hot_buffered_pkg;

  // Widest select vector the legality helper accepts; narrower selects are zero-extended.
  localparam int SEL_MAX_W = 64;

  function automatic logic is_one_hot(input logic [SEL_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - SEL_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/demux_lane_fifo.sv
// Per-consumer synchronous FIFO with wrap-bit pointers; no enqueue-to-output bypass.
module demux_lane_fifo
  import demux_one_hot_buffered_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             enq_valid,
  input  logic [WIDTH-1:0] enq_data,
  output logic             full,
  input  logic             deq_ready,
  output logic             deq_valid,
  output logic [WIDTH-1:0] deq_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             empty;
  logic             do_enq;
  logic             do_deq;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign deq_valid = ~empty;
  assign deq_data  = mem[rptr[AW-1:0]];
  assign do_enq    = enq_valid & ~full;
  assign do_deq    = deq_ready & ~empty;

  // Storage is deliberately left out of reset; only the pointers define contents.
  always_ff @(posedge CLK) begin
    if (do_enq) mem[wptr[AW-1:0]] <= enq_data;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_enq) wptr <= wptr + (AW+1)'(1);
      if (do_deq) rptr <= rptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/demux_one_hot_buffered.sv
// Steers each accepted producer beat to one of COUNT buffered consumer lanes by one-hot select.
module demux_one_hot_buffered
  import demux_one_hot_buffered_pkg::*;
#(
  parameter int COUNT = 4,
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COUNT-1:0]       in_sel_one_hot,
  input  logic [WIDTH-1:0]       in_data,
  output logic [COUNT-1:0]       out_valid_by_consumer,
  input  logic [COUNT-1:0]       out_ready_by_consumer,
  output logic [COUNT*WIDTH-1:0] out_data_by_consumer,
  output logic                   illegal_sel_error
);

  logic [SEL_MAX_W-1:0] sel_ext;
  logic                 sel_legal;
  logic [COUNT-1:0]     full;
  logic                 accept;

  assign sel_ext   = SEL_MAX_W'(in_sel_one_hot);
  assign sel_legal = is_one_hot(sel_ext);
  // Illegal selects are always accepted so they can be dropped without stalling.
  assign in_ready  = sel_legal ? ~|(full & in_sel_one_hot) : 1'b1;
  assign accept    = in_valid & in_ready & sel_legal;

  for (genvar i = 0; i < COUNT; i++) begin : g_lane
    demux_lane_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .CLK       (CLK),
      .nRST      (nRST),
      .enq_valid (accept & in_sel_one_hot[i]),
      .enq_data  (in_data),
      .full      (full[i]),
      .deq_ready (out_ready_by_consumer[i]),
      .deq_valid (out_valid_by_consumer[i]),
      .deq_data  (out_data_by_consumer[i*WIDTH +: WIDTH])
    );
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) illegal_sel_error <= 1'b0;
    else       illegal_sel_error <= in_valid & ~sel_legal;
  end

endmodule

// File: tb/tb_demux_one_hot_buffered.sv
// Randomized and directed self-checking bench for demux_one_hot_buffered against a queue model.
module tb_demux_one_hot_buffered;

  localparam int COUNT = 4;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic                   CLK = 1'b0;
  logic                   nRST;
  logic                   in_valid;
  logic                   in_ready;
  logic [COUNT-1:0]       in_sel_one_hot;
  logic [WIDTH-1:0]       in_data;
  logic [COUNT-1:0]       out_valid_by_consumer;
  logic [COUNT-1:0]       out_ready_by_consumer;
  logic [COUNT*WIDTH-1:0] out_data_by_consumer;
  logic                   illegal_sel_error;

  demux_one_hot_buffered #(.COUNT(COUNT), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK                   (CLK),
    .nRST                  (nRST),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .in_sel_one_hot        (in_sel_one_hot),
    .in_data               (in_data),
    .out_valid_by_consumer (out_valid_by_consumer),
    .out_ready_by_consumer (out_ready_by_consumer),
    .out_data_by_consumer  (out_data_by_consumer),
    .illegal_sel_error     (illegal_sel_error)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] q [COUNT][$];
  logic             err_exp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [COUNT-1:0] exp_valid();
    logic [COUNT-1:0] v = '0;
    for (int i = 0; i < COUNT; i++) v[i] = (q[i].size() != 0);
    return v;
  endfunction

  function automatic logic exp_ready(input logic [COUNT-1:0] sel);
    if ($countones(sel) != 1) return 1'b1;
    for (int i = 0; i < COUNT; i++)
      if (sel[i]) return (q[i].size() < DEPTH);
    return 1'b1;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_ready(in_sel_one_hot)));
    chk({tag, ".out_valid"}, 64'(out_valid_by_consumer), 64'(exp_valid()));
    chk({tag, ".illegal"}, 64'(illegal_sel_error), 64'(err_exp));
    for (int i = 0; i < COUNT; i++)
      if (q[i].size() != 0)
        chk($sformatf("%s.data%0d", tag, i), 64'(out_data_by_consumer[i*WIDTH +: WIDTH]), 64'(q[i][0]));
  endtask

  // Drive one cycle: apply inputs at negedge, check, then advance the model at posedge.
  task automatic step(input string tag, input logic v, input logic [COUNT-1:0] sel,
                      input logic [WIDTH-1:0] d, input logic [COUNT-1:0] rdy);
    logic legal;
    logic acc;
    @(negedge CLK);
    in_valid = v;
    in_sel_one_hot = sel;
    in_data = d;
    out_ready_by_consumer = rdy;
    #1;
    check_outputs(tag);
    legal = ($countones(sel) == 1);
    acc = v && legal && exp_ready(sel);
    @(posedge CLK);
    for (int i = 0; i < COUNT; i++)
      if (rdy[i] && q[i].size() != 0) void'(q[i].pop_front());
    if (acc)
      for (int i = 0; i < COUNT; i++)
        if (sel[i]) q[i].push_back(d);
    err_exp = v && !legal;
  endtask

  task automatic model_reset();
    for (int i = 0; i < COUNT; i++) q[i].delete();
    err_exp = 1'b0;
  endtask

  initial begin
    logic [COUNT-1:0] sel;
    nRST = 1'b0;
    in_valid = 1'b0;
    in_sel_one_hot = '0;
    in_data = '0;
    out_ready_by_consumer = '0;
    model_reset();
    #1;
    chk("rst.out_valid", 64'(out_valid_by_consumer), 64'h0);
    chk("rst.illegal", 64'(illegal_sel_error), 64'h0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    // Idle after reset: every legal select must see ready.
    for (int i = 0; i < COUNT; i++) step("idle", 1'b0, COUNT'(1) << i, '0, '1);

    // Single beat to consumer 2.
    step("single", 1'b1, 4'b0100, 32'hA5A5_0001, 4'b1111);
    step("single1", 1'b0, 4'b0001, '0, 4'b1111);
    chk("single.vld_lit", 64'(out_valid_by_consumer), 64'h4);
    chk("single.dat_lit", 64'(out_data_by_consumer[2*WIDTH +: WIDTH]), 64'hA5A5_0001);
    step("single2", 1'b0, 4'b0001, '0, 4'b1111);
    chk("single.vld_gone", 64'(out_valid_by_consumer), 64'h0);

    // Consumer 1 stalled: fill it, third beat blocks, other lane still flows.
    step("stall1", 1'b1, 4'b0010, 32'd1, 4'b1101);
    step("stall2", 1'b1, 4'b0010, 32'd2, 4'b1101);
    step("stall3", 1'b1, 4'b0010, 32'd3, 4'b1101);
    chk("stall.ready_lit", 64'(in_ready), 64'h0);
    step("other", 1'b1, 4'b1000, 32'hBEEF, 4'b1101);
    step("drain0", 1'b1, 4'b0010, 32'd3, 4'b1111);
    for (int k = 0; k < 4; k++) step("drain", 1'b1, 4'b0010, 32'd3, 4'b1111);
    for (int k = 0; k < 3; k++) step("drainx", 1'b0, 4'b0010, '0, 4'b1111);

    // Illegal selects are swallowed and flag the following cycles.
    step("ill0", 1'b1, 4'b0000, 32'hDEAD, 4'b1111);
    step("ill1", 1'b1, 4'b0110, 32'hDEAD, 4'b1111);
    chk("ill.flag_lit", 64'(illegal_sel_error), 64'h1);
    step("ill2", 1'b0, 4'b0001, '0, 4'b1111);
    step("ill3", 1'b0, 4'b0001, '0, 4'b1111);

    // Steady stream through consumer 0 exercises pointer wrap.
    for (int k = 0; k < 16; k++) step("stream", 1'b1, 4'b0001, 32'(k), 4'b0001);
    for (int k = 0; k < 2; k++) step("streamx", 1'b0, 4'b0001, '0, 4'b0001);

    // Asynchronous reset mid-cycle with consumer 3 holding two beats.
    step("pre_rst1", 1'b1, 4'b1000, 32'h11, 4'b0000);
    step("pre_rst2", 1'b1, 4'b1000, 32'h22, 4'b0000);
    step("pre_rst3", 1'b0, 4'b1000, '0, 4'b0000);
    chk("pre_rst.vld_lit", 64'(out_valid_by_consumer), 64'h8);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst.out_valid", 64'(out_valid_by_consumer), 64'h0);
    chk("arst.illegal", 64'(illegal_sel_error), 64'h0);
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < COUNT; i++) step("post_rst", 1'b0, COUNT'(1) << i, '0, '0);

    // Randomized traffic, mostly legal selects with some illegal ones.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) < 8) sel = COUNT'(1) << $urandom_range(0, COUNT-1);
      else                          sel = COUNT'($urandom);
      step("rand", 1'($urandom_range(0, 3) != 0), sel, $urandom, COUNT'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
